// File: rtl/av_note_judge_pkg.sv
// Shared widths, FSM encoding and note record for the per-string note judge.
// Time compares widen by one bit so a window near 16'hFFFF cannot wrap.
package av_note_judge_pkg;

   localparam int TIME_W             = 16;
   localparam int FRET_W             = 5;
   localparam int DEFAULT_HIT_WINDOW = 10;
   localparam int DEFAULT_DEPTH      = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_JUDGE  = 2'd1,
      ST_RESULT = 2'd2
   } judge_state_e;

   typedef struct packed {
      logic [TIME_W-1:0] t;
      logic [FRET_W-1:0] fret;
   } note_t;

   // a > b + win, evaluated in TIME_W+1 bits
   function automatic logic time_exceeds(input logic [TIME_W-1:0] a,
                                         input logic [TIME_W-1:0] b,
                                         input logic [TIME_W-1:0] win);
      logic [TIME_W:0] sum;
      sum = {1'b0, b} + {1'b0, win};
      return ({1'b0, a} > sum);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/av_note_judge_fifo.sv
// Synchronous note buffer with head peek. A push while full is ignored;
// a pop in the same cycle does not free a slot until the next cycle.
module av_note_judge_fifo
   import av_note_judge_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic  clk,
   input  logic  reset_n,
   input  logic  flush,
   input  logic  push,
   input  note_t push_data,
   input  logic  pop,
   output note_t head,
   output logic  head_valid,
   output logic  full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   note_t          mem_q [DEPTH];
   note_t          mem_d [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic           push_en, pop_en;

   assign head       = mem_q[rd_ptr_q];
   assign head_valid = (count_q != '0);
   assign full       = (count_q == DEPTH_C);
   assign push_en    = push && !full;
   assign pop_en     = pop && head_valid;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/av_note_judge.sv
// Judges strums against the oldest buffered note for one string, expires
// missed notes and keeps hit/miss/streak statistics for the score HUD.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for a strum; strum latches player_fret
//   ST_JUDGE  | compare latched fret with head; stalls while an expiry pops
//   ST_RESULT | match_en shown for a hit; hit_count/streak advance
module av_note_judge
   import av_note_judge_pkg::*;
#(
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int HIT_WINDOW = DEFAULT_HIT_WINDOW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic [TIME_W-1:0] song_time,
   input  logic              note_valid,
   output logic              note_ready,
   input  logic [TIME_W-1:0] note_time,
   input  logic [FRET_W-1:0] note_fret,
   input  logic              strum,
   input  logic [FRET_W-1:0] player_fret,
   output logic              match_en,
   output logic [FRET_W-1:0] match_fret,
   output logic [TIME_W-1:0] match_time,
   output logic              miss_pulse,
   output logic              overstrum_pulse,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count,
   output logic [7:0]        streak
);

   localparam logic [TIME_W-1:0] WIN = TIME_W'(HIT_WINDOW);

   judge_state_e      state_q, state_d;
   logic [FRET_W-1:0] fret_q, fret_d;
   logic              match_en_q, match_en_d;
   logic [FRET_W-1:0] match_fret_q, match_fret_d;
   logic [TIME_W-1:0] match_time_q, match_time_d;
   logic              miss_q, miss_d;
   logic              over_q, over_d;
   logic [15:0]       hit_count_q, hit_count_d;
   logic [15:0]       miss_count_q, miss_count_d;
   logic [7:0]        streak_q, streak_d;

   note_t head;
   note_t push_data;
   logic  head_valid, full;
   logic  push, pop;
   logic  early, expire;

   assign push_data = '{t: note_time, fret: note_fret};
   assign note_ready = !full;
   assign push       = note_valid && !full && !flush;

   assign early  = time_exceeds(head.t, song_time, WIN);
   assign expire = head_valid && time_exceeds(song_time, head.t, WIN);

   av_note_judge_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .head       (head),
      .head_valid (head_valid),
      .full       (full)
   );

   always_comb begin
      state_d      = state_q;
      fret_d       = fret_q;
      match_en_d   = 1'b0;
      match_fret_d = match_fret_q;
      match_time_d = match_time_q;
      miss_d       = 1'b0;
      over_d       = 1'b0;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      streak_d     = streak_q;
      pop          = 1'b0;

      // expiry wins over judging, so JUDGE never pops in the same cycle
      if (expire) begin
         pop          = 1'b1;
         miss_d       = 1'b1;
         miss_count_d = sat_inc16(miss_count_q);
         streak_d     = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (strum) begin
               fret_d  = player_fret;
               state_d = ST_JUDGE;
            end
         end
         ST_JUDGE: begin
            if (!expire) begin
               state_d = ST_RESULT;
               if (!head_valid || early) begin
                  over_d   = 1'b1;
                  streak_d = '0;
               end else if (head.fret == fret_q) begin
                  pop          = 1'b1;
                  match_en_d   = 1'b1;
                  match_fret_d = head.fret;
                  match_time_d = head.t;
               end else begin
                  pop          = 1'b1;
                  miss_d       = 1'b1;
                  miss_count_d = sat_inc16(miss_count_q);
                  streak_d     = '0;
               end
            end
         end
         ST_RESULT: begin
            state_d = ST_IDLE;
            if (match_en_q) begin
               hit_count_d = sat_inc16(hit_count_q);
               streak_d    = expire ? 8'd0 : sat_inc8(streak_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush) begin
         state_d      = ST_IDLE;
         fret_d       = '0;
         match_en_d   = 1'b0;
         match_fret_d = '0;
         match_time_d = '0;
         miss_d       = 1'b0;
         over_d       = 1'b0;
         hit_count_d  = '0;
         miss_count_d = '0;
         streak_d     = '0;
         pop          = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         fret_q       <= '0;
         match_en_q   <= 1'b0;
         match_fret_q <= '0;
         match_time_q <= '0;
         miss_q       <= 1'b0;
         over_q       <= 1'b0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
         streak_q     <= '0;
      end else begin
         state_q      <= state_d;
         fret_q       <= fret_d;
         match_en_q   <= match_en_d;
         match_fret_q <= match_fret_d;
         match_time_q <= match_time_d;
         miss_q       <= miss_d;
         over_q       <= over_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         streak_q     <= streak_d;
      end
   end

   assign match_en        = match_en_q;
   assign match_fret      = match_fret_q;
   assign match_time      = match_time_q;
   assign miss_pulse      = miss_q;
   assign overstrum_pulse = over_q;
   assign hit_count       = hit_count_q;
   assign miss_count      = miss_count_q;
   assign streak          = streak_q;

endmodule
